// File: rtl/async_req_sync_rx.sv
// async_req_sync_rx
// Receives two-phase bundled-data requests from an asynchronous pipeline
// stage. It synchronizes inR into the clk domain, stores inData in a small
// FIFO, returns a two-phase acknowledge on outA, and presents a show-ahead
// valid/ready stream with a registered head word.
//
// Build option: define ASYNC_RX_SYNC3_EN to lengthen the request
// synchronizer from 2 to 3 flops. Every request latency grows by one edge.
module async_req_sync_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inR,
    input  logic [DATA_WIDTH-1:0]   inData,
    output logic                    outA,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Request synchronizer chain; the last stage is the clk-domain request phase.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic s1_q;
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic s2_q;
    logic req_sync_s;

`ifdef ASYNC_RX_SYNC3_EN
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic s3_q;

    // Three-stage synchronizer for high-frequency clk targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= inR;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign req_sync_s = s3_q;
`else
    // Two-stage synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= inR;
            s2_q <= s1_q;
        end
    end

    assign req_sync_s = s2_q;
`endif

    // Phase, pointers, occupancy and the registered head view.
    logic                  req_seen_q, req_seen_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] dout_q,     dout_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic pending_s;
    logic push_s;
    logic pop_s;

    // Next-state logic: accept a pending request when there is room, pop on
    // handshake, and refresh the head view from entries written before this edge.
    always_comb begin
        pending_s  = req_sync_s ^ req_seen_q;
        // Full gating uses the pre-edge count, so a pop at full never makes
        // room for a push in the same cycle.
        push_s     = pending_s && (count_q < CNT_FULL);
        pop_s      = dout_valid_q && dout_ready;

        req_seen_d = req_seen_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push_s) begin
            req_seen_d = ~req_seen_q;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
        end else begin
            req_seen_d = req_seen_q;
            wr_ptr_d   = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Only words already committed before this edge can become the head,
        // so a push into an empty FIFO appears one edge later (no bypass).
        if (pop_s) begin
            dout_valid_d = (count_q > CNT_ONE);
        end else begin
            dout_valid_d = (count_q != CNT_ZERO);
        end

        if (dout_valid_d) begin
            dout_d = mem_q[rd_ptr_d];
        end else begin
            dout_d = dout_q;
        end
    end

    // Control and head-view state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen_q   <= 1'b0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            dout_valid_q <= 1'b0;
            dout_q       <= {DATA_WIDTH{1'b0}};
        end else begin
            req_seen_q   <= req_seen_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    // FIFO storage; inData is sampled only on the push edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: {DATA_WIDTH{1'b0}}};
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= inData;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign outA       = req_seen_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_async_req_sync_rx.sv
// Self-checking bench for async_req_sync_rx: directed steps in one initial
// block, a data scoreboard filled at send time and drained on handshakes,
// and a two-phase protocol monitor on inR.
`timescale 1ns/1ps
module tb_async_req_sync_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef ASYNC_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                   clk;
    logic                   rst;
    logic                   inR;
    logic [DW-1:0]          inData;
    logic                   outA;
    logic                   dout_valid;
    logic                   dout_ready;
    logic [DW-1:0]          dout;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks   = 0;
    int n_pass     = 0;
    int popped     = 0;
    int max_cnt    = 0;
    int ack_cnt    = 0;
    int proto_viol = 0;
    logic last_inR = 1'b0;
    logic [DW-1:0] exp_q [$];

    async_req_sync_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .inR        (inR),
        .inData     (inData),
        .outA       (outA),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nowait(input logic [DW-1:0] d);
        inData = d;
        inR    = ~inR;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (outA !== inR && n < budget) begin
            tick();
            n++;
        end
        chk("ack_within_budget", 64'(outA), 64'(inR));
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        exp_q.push_back(d);
        send_nowait(d);
        wait_ack(20);
    endtask

    task automatic pulse_ready();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    // Scoreboard: compare every handshaken head word with the oldest sent word.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (dout_valid && dout_ready) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_data", 64'(dout), 64'(exp_q.pop_front()));
                end
                popped++;
            end
        end
    end

    // Protocol monitor: a new inR toggle while the previous one is unacked.
    always @(inR) begin
        if (rst === 1'b0 && last_inR !== outA) proto_viol++;
        last_inR = inR;
    end

    // Acknowledge toggle counter.
    always @(outA) begin
        if (rst === 1'b0) ack_cnt++;
    end

    initial begin
        int base_ack;
        int base_pop;
        int viol0;
        int n;

        // Reset with random inputs.
        rst = 1'b1; inR = 1'b0; inData = '0; dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inR        = 1'($urandom_range(0, 1));
            inData     = $urandom;
            dout_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_outA", 64'(outA), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        inR = 1'b0; inData = '0; dout_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_after_rst", 64'({outA, dout_valid, fifo_count}), 64'd0);
        end

        // Single word: ack exactly LAT edges after the first sampling edge.
        exp_q.push_back(32'hA5A5_0001);
        send_nowait(32'hA5A5_0001);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("single_ack_latency", 64'(outA), 64'(k == LAT));
        end
        chk("single_no_bypass", 64'(dout_valid), 64'd0);
        chk("single_count", 64'(fifo_count), 64'd1);
        tick();
        chk("single_valid", 64'(dout_valid), 64'd1);
        chk("single_dout", 64'(dout), 64'hA5A5_0001);
        pulse_ready();
        chk("single_pop_valid", 64'(dout_valid), 64'd0);
        chk("single_pop_count", 64'(fifo_count), 64'd0);
        chk("single_popped", 64'(popped), 64'd1);

        // Fill to full, 5th request withheld until a pop frees space.
        base_ack = ack_cnt;
        for (int w = 1; w <= 4; w++) send_word(DW'(w));
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_acks", 64'(ack_cnt - base_ack), 64'd4);
        exp_q.push_back(32'd5);
        send_nowait(32'd5);
        repeat (10) tick();
        chk("full_pending", 64'(outA ^ inR), 64'd1);
        chk("full_count_hold", 64'(fifo_count), 64'd4);
        chk("full_acks_hold", 64'(ack_cnt - base_ack), 64'd4);
        pulse_ready();
        chk("full_pop_count", 64'(fifo_count), 64'd3);
        chk("full_pop_still_pending", 64'(outA ^ inR), 64'd1);
        tick();
        chk("full_5th_acked", 64'(outA ^ inR), 64'd0);
        chk("full_refill_count", 64'(fifo_count), 64'd4);
        chk("full_acks_total", 64'(ack_cnt - base_ack), 64'd5);
        dout_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        dout_ready = 1'b0;
        tick();
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_count", 64'(fifo_count), 64'd0);
        chk("drain_popped", 64'(popped), 64'd6);

        // Concurrent push/pop across pointer wrap.
        dout_ready = 1'b1;
        max_cnt    = 0;
        base_pop   = popped;
        for (int w = 0; w < 16; w++) send_word(DW'(w));
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        dout_ready = 1'b0;
        chk("stream_popped", 64'(popped - base_pop), 64'd16);
        chk("stream_max_count", 64'(max_cnt), 64'd1);
        chk("stream_count_end", 64'(fifo_count), 64'd0);

        // Reset mid-stream: 2 stored, 1 pending.
        send_word(32'h0000_0011);
        send_word(32'h0000_0022);
        send_nowait(32'h0000_0033);
        tick();
        chk("mid_count", 64'(fifo_count), 64'd2);
        chk("mid_pending", 64'(outA ^ inR), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outA", 64'(outA), 64'd0);
        chk("mid_rst_valid", 64'(dout_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_dout", 64'(dout), 64'd0);
        exp_q.delete();
        inR = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_idle", 64'({outA, dout_valid, fifo_count}), 64'd0);
        send_word(32'h5A5A_0077);
        tick();
        chk("mid_fresh_valid", 64'(dout_valid), 64'd1);
        chk("mid_fresh_dout", 64'(dout), 64'h5A5A_0077);
        pulse_ready();
        chk("mid_fresh_count", 64'(fifo_count), 64'd0);
        chk("mid_fresh_sb", 64'(exp_q.size()), 64'd0);

        // Protocol violation: two inR toggles without an intervening ack.
        viol0 = proto_viol;
        inR = ~inR;
        #1;
        inR = ~inR;
        #1;
        chk("proto_violation_flagged", 64'(proto_viol - viol0), 64'd1);
        rst = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
